mem_1r1w_masked_32x64_arb: RTL

Arbiter and sequencer for one `mem_1r1w_masked_32x64` instance. It shares the single read port between two read requesters and the single masked write port between two write requesters, using round-robin grants. After reset it clears all 32 entries before accepting traffic. It resolves same-cycle read/write address collisions deterministically, because the memory macro does not define read-during-write results. It sits between the client pipelines and the memory wrapper; all sides run on one clock.

---
 rtl/mem_1r1w_masked_32x64_arb_pkg.sv | 27 ++
 rtl/mem_1r1w_masked_32x64_arb_if.sv | 60 ++++++
 rtl/mem_1r1w_masked_32x64_arb_rr_arb2.sv | 28 ++
 rtl/mem_1r1w_masked_32x64_arb.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mem_1r1w_masked_32x64_arb_pkg.sv
// Shared geometry, FSM state type and helpers for the 32x64 masked-memory arbiter.
package mem_arb_pkg;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;
    localparam int MASK_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN
    } state_t;

    typedef logic [ADDR_W-1:0] addr_t;

    // Widens a byte-enable mask into a per-bit data mask.
    function automatic logic [DATA_W-1:0] expand_mask(input logic [MASK_W-1:0] m);
        logic [DATA_W-1:0] res;
        res = '0;
        for (int i = 0; i < MASK_W; i++) begin
            res[8*i +: 8] = {8{m[i]}};
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_1r1w_masked_32x64_arb_if.sv
// Client request/response and memory-port bundle for the arbiter; slave = arbiter side.
interface mem_1r1w_masked_32x64_arb_if;
    import mem_arb_pkg::*;

    logic              rd0_valid;
    logic              rd1_valid;
    addr_t             rd0_addr;
    addr_t             rd1_addr;
    logic              rd0_ready;
    logic              rd1_ready;
    logic              rd0_rvalid;
    logic              rd1_rvalid;
    logic [DATA_W-1:0] rd_rdata;

    logic              wr0_valid;
    logic              wr1_valid;
    addr_t             wr0_addr;
    addr_t             wr1_addr;
    logic [DATA_W-1:0] wr0_data;
    logic [DATA_W-1:0] wr1_data;
    logic [MASK_W-1:0] wr0_mask;
    logic [MASK_W-1:0] wr1_mask;
    logic              wr0_ready;
    logic              wr1_ready;

    logic              init_done;

    addr_t             R0_addr;
    logic              R0_en;
    logic [DATA_W-1:0] R0_data;
    addr_t             W0_addr;
    logic              W0_en;
    logic [DATA_W-1:0] W0_data;
    logic [MASK_W-1:0] W0_mask;

    modport slave (
        input  rd0_valid, rd1_valid, rd0_addr, rd1_addr,
        output rd0_ready, rd1_ready, rd0_rvalid, rd1_rvalid, rd_rdata,
        input  wr0_valid, wr1_valid, wr0_addr, wr1_addr,
        input  wr0_data, wr1_data, wr0_mask, wr1_mask,
        output wr0_ready, wr1_ready,
        output init_done,
        output R0_addr, R0_en,
        input  R0_data,
        output W0_addr, W0_en, W0_data, W0_mask
    );

    modport master (
        output rd0_valid, rd1_valid, rd0_addr, rd1_addr,
        input  rd0_ready, rd1_ready, rd0_rvalid, rd1_rvalid, rd_rdata,
        output wr0_valid, wr1_valid, wr0_addr, wr1_addr,
        output wr0_data, wr1_data, wr0_mask, wr1_mask,
        input  wr0_ready, wr1_ready,
        input  init_done,
        input  R0_addr, R0_en,
        output R0_data,
        input  W0_addr, W0_en, W0_data, W0_mask
    );

endinterface

// File: rtl/mem_1r1w_masked_32x64_arb_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer moves past the winner only when advance is set.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

    // Caller only raises advance when some grant is live, so grant[1] identifies the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~grant[1];
        end
    end

endmodule

// File: rtl/mem_1r1w_masked_32x64_arb.sv
// Round-robin read/write arbiter and power-on clear sequencer for a 32x64 masked 1R1W memory.
// Optional feature: define MEM_ARB_BYPASS_EN to forward colliding write bytes instead of stalling the read.
module mem_1r1w_masked_32x64_arb
    import mem_arb_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst_n,
    mem_1r1w_masked_32x64_arb_if.slave           bus
);

    state_t            state;
    state_t            state_next;
    addr_t             cnt;
    logic              run;

    logic [1:0]        rd_grant;
    logic [1:0]        wr_grant;
    logic              rd_any;
    logic              wr_any;
    logic              rd_sel;
    logic              wr_sel;
    addr_t             rd_addr;
    addr_t             wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [MASK_W-1:0] wr_mask;
    logic              collide;
    logic              rd_fire;
    logic              wr_fire;

    logic              rsp_valid;
    logic              rsp_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = CLEAR;
            CLEAR:   if (cnt == addr_t'(DEPTH - 1)) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    assign run = (state == RUN);

    rr_arb2 u_rd_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   ({bus.rd1_valid, bus.rd0_valid}),
        .advance (rd_fire),
        .grant   (rd_grant)
    );

    rr_arb2 u_wr_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   ({bus.wr1_valid, bus.wr0_valid}),
        .advance (wr_fire),
        .grant   (wr_grant)
    );

    assign rd_any  = |rd_grant;
    assign wr_any  = |wr_grant;
    assign rd_sel  = rd_grant[1];
    assign wr_sel  = wr_grant[1];
    assign rd_addr = rd_sel ? bus.rd1_addr : bus.rd0_addr;
    assign wr_addr = wr_sel ? bus.wr1_addr : bus.wr0_addr;
    assign wr_data = wr_sel ? bus.wr1_data : bus.wr0_data;
    assign wr_mask = wr_sel ? bus.wr1_mask : bus.wr0_mask;
    assign collide = run & rd_any & wr_any & (rd_addr == wr_addr);

    // The macro's read-during-write result is undefined, so a colliding read is either patched or held off.
`ifdef MEM_ARB_BYPASS_EN
    assign rd_fire = run & rd_any;
`else
    assign rd_fire = run & rd_any & ~collide;
`endif
    assign wr_fire = run & wr_any;

    assign bus.rd0_ready = rd_fire & ~rd_sel;
    assign bus.rd1_ready = rd_fire & rd_sel;
    assign bus.wr0_ready = wr_fire & ~wr_sel;
    assign bus.wr1_ready = wr_fire & wr_sel;
    assign bus.init_done = run;

    assign bus.R0_en   = rd_fire;
    assign bus.R0_addr = rd_fire ? rd_addr : '0;

    always_comb begin
        bus.W0_en   = 1'b0;
        bus.W0_addr = '0;
        bus.W0_data = '0;
        bus.W0_mask = '0;
        case (state)
            CLEAR: begin
                bus.W0_en   = 1'b1;
                bus.W0_addr = cnt;
                bus.W0_mask = '1;
            end
            RUN: begin
                if (wr_fire) begin
                    bus.W0_en   = 1'b1;
                    bus.W0_addr = wr_addr;
                    bus.W0_data = wr_data;
                    bus.W0_mask = wr_mask;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
        end else begin
            rsp_valid <= rd_fire;
            if (rd_fire) begin
                rsp_id <= rd_sel;
            end
        end
    end

    assign bus.rd0_rvalid = rsp_valid & ~rsp_id;
    assign bus.rd1_rvalid = rsp_valid & rsp_id;

`ifdef MEM_ARB_BYPASS_EN
    logic [DATA_W-1:0] byp_data;
    logic [MASK_W-1:0] byp_mask;

    // A zero mask on non-colliding reads makes the merge transparent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_data <= '0;
            byp_mask <= '0;
        end else if (rd_fire) begin
            byp_data <= wr_data;
            byp_mask <= collide ? wr_mask : '0;
        end
    end

    assign bus.rd_rdata = (bus.R0_data & ~expand_mask(byp_mask)) |
                          (byp_data & expand_mask(byp_mask));
`else
    assign bus.rd_rdata = bus.R0_data;
`endif

endmodule
